// File: rtl/jk_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_driver
// Brief    : Drives an external JK flip-flop from a stream of target Q bits.
//            A small FIFO buffers the targets. Each bit takes three cycles.
//            IDLE pops the bit and registers J/K. APPLY holds J/K for the
//            flop to sample. CHECK compares the Q feedback against the target
//            and updates the counters.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_driver #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int TOGGLE_PREF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             chk_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head;
  logic            tgt;
  logic [1:0]      jk_ex;

  // FIFO status. Acceptance depends only on full, so a pop in the same
  // cycle never frees a slot for a push.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign head     = fifo_mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;

  // Target storage. This needs no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_bit;
    end
  end

  // Pointer and occupancy tracking. Pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // JK excitation for the transition from the current Q to the head target.
  // Hold transitions always drive 0/0. Set and reset use single-sided drive
  // unless toggle is preferred.
  always_comb begin
    jk_ex = 2'b00;
    if (q_fb != head) begin
      if (TOGGLE_PREF != 0) begin
        jk_ex = 2'b11;
      end else begin
        jk_ex = head ? 2'b10 : 2'b01;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Each bit takes a fixed IDLE -> APPLY -> CHECK pass.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = APPLY;
      APPLY:   state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // J/K drive, target capture, check pulses and counters.
  // J/K are nonzero only during the APPLY cycle, so the flop holds at all other times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j         <= 1'b0;
      k         <= 1'b0;
      tgt       <= 1'b0;
      chk_pulse <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      j         <= pop && jk_ex[1];
      k         <= pop && jk_ex[0];
      chk_pulse <= (state == CHECK);
      err_pulse <= (state == CHECK) && (q_fb != tgt);
      if (pop) begin
        tgt <= head;
      end
      if (state == CHECK) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if ((q_fb != tgt) && (err_cnt != '1)) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/jk_seq_driver.md
Name: jk_seq_driver

Overview:
- Drives an external jkff from a stream of target Q bits. Per bit, derives J/K from the JK excitation table and the current Q feedback, applies them for one clock, then checks that Q reached the target.
- Replaces hand-written J/K stimulus sequences in sequential-logic benches and in small on-chip self-checks.
- Input side is a valid/ready stream buffered in a small FIFO.
- Output side is the j/k pair, plus error and progress counters.

Parameters:
- DEPTH, 4, target-bit FIFO entries (power of 2, >=2).
- CNT_W, 8, width of err_cnt and bit_cnt.
- TOGGLE_PREF, 0: 0 resolves don't-cares to set/reset (J=1,K=0 / J=0,K=1); 1 uses toggle (J=1,K=1) for every transition.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  target bit offered
- in_bit  in  1  target Q value
- in_ready  out  1  FIFO can accept; equals !full
- q_fb  in  1  Q output of the driven jkff
- j  out  1  J drive to jkff, registered
- k  out  1  K drive to jkff, registered
- busy  out  1  high when FSM is not in IDLE or FIFO is non-empty
- chk_pulse  out  1  one-cycle pulse when a bit is checked
- err_pulse  out  1  one-cycle pulse on mismatch, coincident with chk_pulse
- err_cnt  out  CNT_W  mismatch count, saturating
- bit_cnt  out  CNT_W  checked-bit count, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): FIFO emptied (pointers and count = 0); state=IDLE; j=0, k=0; chk_pulse=0, err_pulse=0; err_cnt=0, bit_cnt=0; busy=0; in_ready=1. Reset mid-operation abandons the bit in flight without counting it. The jkff shares rst, so q_fb=0 after reset.
- Push: on clk edge with in_valid & in_ready, in_bit is written.
  - in_ready depends only on full. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full keeps the count unchanged.
- FSM states: IDLE, APPLY, CHECK. Each bit takes exactly 3 cycles; throughput is 1 bit per 3 clocks.
- IDLE:
  - FIFO empty: stay in IDLE with j=k=0.
  - FIFO non-empty: pop the head into tgt and register j/k from (q_fb, head), then go to APPLY.
  - Excitation with TOGGLE_PREF=0: 0->0 gives j=0,k=0; 0->1 gives j=1,k=0; 1->0 gives j=0,k=1; 1->1 gives j=0,k=0.
  - Excitation with TOGGLE_PREF=1: 0->1 and 1->0 give j=1,k=1; holds give j=0,k=0.
- APPLY:
  - j/k are stable for this whole cycle. The jkff samples them on the edge that leaves APPLY.
  - On that same edge j,k return to 0,0; go to CHECK.
- CHECK:
  - q_fb reflects the applied J/K. On the edge leaving CHECK, chk_pulse=1 for one cycle, bit_cnt increments, and the FSM returns to IDLE.
  - If q_fb != tgt: err_pulse=1 and err_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- j and k are never both 1 when TOGGLE_PREF=0. Outside APPLY, j=k=0, so the flop holds.
- Counters are read-only and cleared only by rst.

Test Plan:
- Reset then idle: assert rst for 15 ns, no input -> j=k=0, busy=0, in_ready=1, err_cnt=0, bit_cnt=0.
- Sequence 1,1,0,1,0 pushed back-to-back (TOGGLE_PREF=0, good jkff, q starts 0):
  - j/k during APPLY cycles = (1,0), (0,0), (0,1), (1,0), (0,1).
  - chk_pulse five times, 3 cycles apart; bit_cnt=5, err_cnt=0.
- TOGGLE_PREF=1, same sequence -> j/k during APPLY = (1,1), (0,0), (1,1), (1,1), (1,1); err_cnt=0.
- Back-pressure with DEPTH=4: hold in_valid=1 for 10 cycles.
  - in_ready drops after the FIFO fills.
  - Exactly 4 + (pops during the window) bits accepted; no bit lost or duplicated (bit_cnt matches accepted count at drain).
- Fault injection (q_fb tied 0), targets 1,0,1:
  - err_pulse on 1st and 3rd checks only; err_cnt=2, bit_cnt=3.
  - With CNT_W=2 and 5 forced errors, err_cnt saturates at 3.
- Reset mid-APPLY with 3 bits queued -> next cycle j=k=0, state IDLE, FIFO empty, counters 0; no chk_pulse for the abandoned bit.
